// File: rtl/full_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// full_subtractor_pkg
//   Shared definitions for the ripple-borrow subtractor.
//   WIDTH_MAX  : largest chain length the subtractor is intended for.
//   cell_res_t : result pair of a half subtractor (difference bit, borrow bit).
// -----------------------------------------------------------------------------
package full_subtractor_pkg;

   localparam int WIDTH_MAX = 64;

   typedef struct packed {
      logic d;
      logic bo;
   } cell_res_t;

endpackage : full_subtractor_pkg

// File: rtl/full_subtractor_half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
//   Single-bit half subtractor built from gate primitives: x - y.
//   Ports:
//     x  in  minuend bit
//     y  in  subtrahend bit
//     d  out difference bit  (x ^ y)
//     bo out borrow bit      (~x & y)
// -----------------------------------------------------------------------------
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   logic x_n;

   xor g_xor (d, x, y);
   not g_not (x_n, x);
   and g_and (bo, x_n, y);

endmodule : half_subtractor

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   WIDTH-cell ripple-borrow subtractor computing a - b - bor_in, with the
//   difference and final borrow captured in one output register stage.
//   Each cell is two half subtractors plus an OR that merges their borrows.
//   Ports:
//     clk     in  rising-edge clock
//     rst_n   in  asynchronous active-low reset, clears the outputs
//     a       in  [WIDTH-1:0] minuend
//     b       in  [WIDTH-1:0] subtrahend
//     bor_in  in  borrow into bit 0
//     diff    out [WIDTH-1:0] registered difference (wraps modulo 2^WIDTH)
//     bor_out out registered borrow out of bit WIDTH-1 (1 when a < b + bor_in)
// -----------------------------------------------------------------------------
module full_subtractor
   import full_subtractor_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bor_in,
   output logic [WIDTH-1:0] diff,
   output logic             bor_out
);

   // Reject chain lengths outside the supported range at elaboration.
   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("full_subtractor: WIDTH %0d outside 1..%0d", WIDTH, WIDTH_MAX);
   end

   // borrow[i] enters cell i; borrow[WIDTH] leaves the top cell.
   logic [WIDTH:0]        borrow;
   cell_res_t [WIDTH-1:0] hs1_res;   // a ^ b, ~a & b
   cell_res_t [WIDTH-1:0] hs2_res;   // final difference bit, borrow from chain

   logic [WIDTH-1:0] diff_d;
   logic             bor_out_d;
   logic [WIDTH-1:0] diff_q;
   logic             bor_out_q;

   assign borrow[0] = bor_in;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      half_subtractor u_hs1 (
         .x  (a[gi]),
         .y  (b[gi]),
         .d  (hs1_res[gi].d),
         .bo (hs1_res[gi].bo)
      );

      half_subtractor u_hs2 (
         .x  (hs1_res[gi].d),
         .y  (borrow[gi]),
         .d  (hs2_res[gi].d),
         .bo (hs2_res[gi].bo)
      );

      // The two borrow sources are mutually exclusive, so OR is exact.
      or g_bor (borrow[gi+1], hs1_res[gi].bo, hs2_res[gi].bo);
   end

   always_comb begin
      diff_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         diff_d[i] = hs2_res[i].d;
      end
      bor_out_d = borrow[WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q    <= '0;
         bor_out_q <= 1'b0;
      end else begin
         diff_q    <= diff_d;
         bor_out_q <= bor_out_d;
      end
   end

   assign diff    = diff_q;
   assign bor_out = bor_out_q;

endmodule : full_subtractor

// File: tb/tb_full_subtractor.sv
// -----------------------------------------------------------------------------
// tb_full_subtractor
//   Drives a WIDTH=1 and a WIDTH=8 instance side by side. Expected values
//   come from constant tables and from an integer-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_full_subtractor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a1, b1, c1;
   logic [0:0] d1;
   logic       bo1;
   logic [7:0] a8, b8, d8;
   logic       c8, bo8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   full_subtractor #(.WIDTH(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a1),
      .b       (b1),
      .bor_in  (c1),
      .diff    (d1),
      .bor_out (bo1)
   );

   full_subtractor #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a8),
      .b       (b8),
      .bor_in  (c8),
      .diff    (d8),
      .bor_out (bo8)
   );

   typedef struct {
      logic a, b, c;
      logic e_d, e_bo;
   } vec1_t;

   typedef struct {
      logic [7:0] a, b;
      logic       c;
      logic [7:0] e_d;
      logic       e_bo;
   } vec8_t;

   // Plain integer subtraction: borrow when negative, difference modulo 2^width.
   function automatic void ref_sub(input int a, input int b, input int c,
                                   input int width, output int d, output int bo);
      int m;
      int r;
      m  = 1 << width;
      r  = a - b - c;
      bo = (r < 0) ? 1 : 0;
      d  = (r + m) % m;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
      end
   endtask

   task automatic drive(input logic ia1, input logic ib1, input logic ic1,
                        input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8);
      @(negedge clk);
      a1 = ia1; b1 = ib1; c1 = ic1;
      a8 = ia8; b8 = ib8; c8 = ic8;
   endtask

   task automatic expect_out(input string tag,
                             input logic e_d1, input logic e_bo1,
                             input logic [7:0] e_d8, input logic e_bo8);
      @(posedge clk);
      #1;
      chk({tag, "_d1"},  {7'd0, d1},  {7'd0, e_d1});
      chk({tag, "_bo1"}, {7'd0, bo1}, {7'd0, e_bo1});
      chk({tag, "_d8"},  d8,          e_d8);
      chk({tag, "_bo8"}, {7'd0, bo8}, {7'd0, e_bo8});
      $display("txn %s: w1 d=%0b bo=%0b | w8 d=0x%h bo=%0b", tag, d1, bo1, d8, bo8);
   endtask

   // Drive random operands on both instances and check against ref_sub.
   task automatic random_step(input string tag);
      int ra1, rb1, rc1, ra8, rb8, rc8, ed1, eb1, ed8, eb8;
      ra1 = int'($urandom_range(0, 1));
      rb1 = int'($urandom_range(0, 1));
      rc1 = int'($urandom_range(0, 1));
      ra8 = int'($urandom_range(0, 255));
      rb8 = int'($urandom_range(0, 255));
      rc8 = int'($urandom_range(0, 1));
      ref_sub(ra1, rb1, rc1, 1, ed1, eb1);
      ref_sub(ra8, rb8, rc8, 8, ed8, eb8);
      drive(ra1[0], rb1[0], rc1[0], ra8[7:0], rb8[7:0], rc8[0]);
      expect_out(tag, ed1[0], eb1[0], ed8[7:0], eb8[0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec1_t tt1[8];
      vec8_t tt8[6];
      int    ed, eb;

      // Truth table (a,b,bor_in) -> (diff,bor_out) for a single cell.
      tt1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tt1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tt1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tt1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tt1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tt1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tt1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tt1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // 8-bit corner vectors: wrap, full ripple, no borrow, equality, extremes.
      tt8[0] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      tt8[1] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      tt8[2] = '{8'hA5, 8'h25, 1'b1, 8'h7F, 1'b0};
      tt8[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0};
      tt8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tt8[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

      // Asynchronous reset with all-ones single-bit inputs, before any edge.
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      a8 = 8'h10; b8 = 8'h01; c8 = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_d1",  {7'd0, d1},  8'h00);
      chk("rst_async_bo1", {7'd0, bo1}, 8'h00);
      chk("rst_async_d8",  d8,          8'h00);
      chk("rst_async_bo8", {7'd0, bo8}, 8'h00);

      // Outputs hold at zero across edges while reset stays low.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_d1", {7'd0, d1}, 8'h00);
      chk("rst_hold_d8", d8,         8'h00);
      chk("rst_hold_bo", {6'd0, bo1, bo8}, 8'h00);

      @(negedge clk);
      rst_n = 1'b1;
      expect_out("rst_release", 1'b1, 1'b1, 8'h0F, 1'b0);

      // Exhaustive single-bit table, back-to-back, 8-bit side gets corner vectors.
      for (int i = 0; i < 8; i++) begin
         drive(tt1[i].a, tt1[i].b, tt1[i].c,
               tt8[i % 6].a, tt8[i % 6].b, tt8[i % 6].c);
         expect_out($sformatf("table%0d", i), tt1[i].e_d, tt1[i].e_bo,
                    tt8[i % 6].e_d, tt8[i % 6].e_bo);
      end

      // Inputs changed after an edge must not reach the outputs before the next edge.
      drive(1'b0, 1'b1, 1'b0, 8'h03, 8'h01, 1'b0);
      expect_out("hold_pre", 1'b1, 1'b1, 8'h02, 1'b0);
      #1;
      a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
      a8 = 8'h00; b8 = 8'h80; c8 = 1'b1;
      #2;
      chk("hold_d1", {7'd0, d1}, 8'h01);
      chk("hold_d8", d8,         8'h02);
      chk("hold_bo", {6'd0, bo1, bo8}, 8'h02);
      expect_out("hold_post", 1'b1, 1'b0, 8'h7F, 1'b1);

      // Mid-stream reset pulse between edges; the next vector must be clean.
      drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
      expect_out("mid_pre", 1'b1, 1'b1, 8'hFF, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'h25, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d1", {7'd0, d1}, 8'h00);
      chk("mid_rst_d8", d8,         8'h00);
      chk("mid_rst_bo", {6'd0, bo1, bo8}, 8'h00);
      #1;
      rst_n = 1'b1;
      expect_out("mid_post", 1'b1, 1'b0, 8'h7F, 1'b0);

      // Sanity of the reference against one hand-derived value.
      ref_sub(0, 1, 0, 8, ed, eb);
      chk("ref_wrap", ed[7:0], 8'hFF);

      // Randomized back-to-back traffic against the integer reference.
      for (int n = 0; n < 300; n++) begin
         random_step($sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_full_subtractor
